keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Upstream input stage of the calculator. Scans a 4x4 active-low matrix keypad, synchronizes and debounces the column lines, and decodes each accepted keypress.
- Produces the digit, operator and equal strobes consumed by the calculator controller (gencon): keypad_input, read_input, operator_input and equal_input.
- Also produces a clear strobe for the controller.

Parameters:
- SCAN_CYCLES, 4: clocks each row is driven before its columns are sampled; must be >= 3 to cover the synchronizer.
- DEBOUNCE_CYCLES, 16: consecutive stable samples required to accept a press or a release; must be >= 2.

Ports:
- clk  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- col_in  input  4  raw column lines, active-low, pulled up externally, asynchronous to clk
- row_out  output  4  row drive, active-low, one-hot-zero
- keypad_input  output  4  last accepted digit 0-9; held between presses
- read_input  output  1  1-clock strobe: keypad_input is new
- operator_input  output  3  sticky one-hot: 001 add, 010 subtract, 100 multiply, 000 none
- equal_input  output  1  1-clock strobe: equal key
- clear_input  output  1  1-clock strobe: clear key

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on nRST.
- Reset values:
  - row_out=4'b1110 (row 0).
  - keypad_input=0, read_input=0, operator_input=000, equal_input=0, clear_input=0.
  - FSM=SCAN, row index=0, all counters=0, synchronizer flops=4'b1111.
  - Reset asserted mid-operation aborts immediately. A key still held after reset release is re-detected from SCAN, and a strobe fires only after a full debounce.
- Synchronizer: col_in passes through a 2-flop synchronizer giving col_s. All decisions use col_s only.
- Key map (row,col):
  - r0: 1, 2, 3, add
  - r1: 4, 5, 6, sub
  - r2: 7, 8, 9, mul
  - r3: clear, 0, equal, unused
  - The unused key is accepted and debounced like any key but produces no output.
- FSM states:
  - SCAN:
    - Drive row index low. Dwell counter runs 0..SCAN_CYCLES-1; sample col_s when it reaches SCAN_CYCLES-1.
    - Exactly one column low: latch row and column pattern, go to PRESS_DB.
    - Zero or more than one column low: advance row index (3 wraps to 0), reset dwell, stay in SCAN. Multi-key chords are ignored.
  - PRESS_DB:
    - Hold the row. Count cycles where col_s equals the latched pattern.
    - Any mismatch: clear the count and return to SCAN on the same row.
    - Count reaches DEBOUNCE_CYCLES-1: go to EMIT.
  - EMIT: exactly one clock, then go to RELEASE_DB. Output registers update on entry to EMIT:
    - Digit: keypad_input <= digit, read_input=1.
    - add/sub/mul: operator_input <= 001/010/100. Overwrites any previous value; no strobe.
    - Equal: equal_input=1.
    - Clear: clear_input=1 and operator_input <= 000. keypad_input is unchanged.
  - RELEASE_DB:
    - Hold the row. Count consecutive cycles with col_s==4'b1111; any low column clears the count.
    - Count reaches DEBOUNCE_CYCLES-1: advance row index and return to SCAN.
    - A held key therefore produces exactly one strobe; there is no auto-repeat.
- Strobes: read_input, equal_input and clear_input are high for exactly one clock, during EMIT, and are never simultaneous.
- operator_input: changes only in EMIT or on reset, so it stays level-stable for gencon's SEND_TO_ALU sampling.
- Latency: from col_in stable low at row-sample time to strobe is 2 (sync) + DEBOUNCE_CYCLES + 1 clocks.
- Minimum press-to-press spacing: DEBOUNCE_CYCLES (press) + 1 + DEBOUNCE_CYCLES (release) + scan time.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. Counters saturate and never wrap.

Test Plan:
All scenarios use SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
1. Reset, then hold r1c1 (key 5) clean for 60 clocks -> exactly one read_input pulse with keypad_input=5; no further pulses while held; keypad_input stays 5 after release.
2. Press r0c3 (add), then r2c0 (7), then r3c2 (equal) with clean release between each -> operator_input=001 from add EMIT onward; read_input with digit 7; one equal_input pulse; operator_input still 001 after equal.
3. Press r2c3 (mul) after step 2, then r3c0 (clear) -> operator_input 001->100->000; single clear_input pulse; keypad_input unchanged at 7.
4. Key 0 (r3c1) bouncing low/high every 3 clocks for 40 clocks, then stable low -> no strobe during bounce; exactly one read_input with keypad_input=0, 2+8+1 clocks after stable low is sampled.
5. Two columns low together on r0 (keys 1 and 2) -> no strobe; row_out continues cycling 1110->1101->1011->0111->1110.
6. nRST low for 1 clock during PRESS_DB on key 9, key still held -> all outputs reset, row_out=1110; exactly one read_input with keypad_input=9 after a fresh full debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces presses and releases, and decodes them into calculator strobes
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input,
  output logic       clear_input
);
  localparam int SW = ($clog2(SCAN_CYCLES) < 1) ? 1 : $clog2(SCAN_CYCLES);
  localparam int DW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, EMIT, RELEASE_DB} state_t;

  state_t        state;
  logic [3:0]    sync1, col_s, pat, col_low;
  logic [1:0]    idx, col_idx;
  logic [SW-1:0] dwell;
  logic [DW-1:0] cnt;
  logic [3:0]    key, digit;
  logic [2:0]    op_val;
  logic          one_low, is_digit, is_op, is_eq, is_clr;

  // two-flop synchronizer; idle lines read as released
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      sync1 <= 4'hF;
      col_s <= 4'hF;
    end else begin
      sync1 <= col_in;
      col_s <= sync1;
    end

  // exactly one low column qualifies as a single keypress; decode the latched key
  always_comb begin
    col_low  = ~col_s;
    one_low  = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
    col_idx  = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
    key      = {idx, col_idx};
    is_digit = (idx != 2'd3 && col_idx != 2'd3) || key == 4'd13;
    digit    = key == 4'd13 ? 4'd0 : 4'(({2'b00, idx} * 4'd3) + {2'b00, col_idx} + 4'd1);
    is_op    = col_idx == 2'd3 && idx != 2'd3;
    op_val   = 3'b001 << idx;
    is_eq    = key == 4'd14;
    is_clr   = key == 4'd12;
  end

  // scan/debounce/emit FSM with registered row drive and output strobes
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      state          <= SCAN;
      idx            <= 2'd0;
      row_out        <= 4'b1110;
      dwell          <= '0;
      cnt            <= '0;
      pat            <= 4'hF;
      keypad_input   <= 4'd0;
      read_input     <= 1'b0;
      operator_input <= 3'b000;
      equal_input    <= 1'b0;
      clear_input    <= 1'b0;
    end else begin
      read_input  <= 1'b0;
      equal_input <= 1'b0;
      clear_input <= 1'b0;
      case (state)
        SCAN:
          if (dwell != SCAN_LAST) dwell <= dwell + 1'b1;
          else begin
            dwell <= '0;
            cnt   <= '0;
            if (one_low) begin
              pat   <= col_s;
              state <= PRESS_DB;
            end else begin
              idx     <= idx + 2'd1;
              row_out <= ~(4'b0001 << (idx + 2'd1));
            end
          end
        PRESS_DB:
          if (col_s != pat) begin
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == DB_LAST) begin
            state <= EMIT;
            if (is_digit) begin
              keypad_input <= digit;
              read_input   <= 1'b1;
            end
            if (is_op) operator_input <= op_val;
            if (is_eq) equal_input <= 1'b1;
            if (is_clr) begin
              clear_input    <= 1'b1;
              operator_input <= 3'b000;
            end
          end else cnt <= cnt + 1'b1;
        EMIT: begin
          cnt   <= '0;
          state <= RELEASE_DB;
        end
        RELEASE_DB:
          if (col_s != 4'hF) cnt <= '0;
          else if (cnt == DB_LAST) begin
            state   <= SCAN;
            dwell   <= '0;
            cnt     <= '0;
            idx     <= idx + 2'd1;
            row_out <= ~(4'b0001 << (idx + 2'd1));
          end else cnt <= cnt + 1'b1;
        default: state <= SCAN;
      endcase
    end
endmodule
